// File: rtl/operand_forward_stage.sv
// Operand forwarding stage: R->C operand register, C->M result register,
// post-writeback capture register and the per-operand forwarding muxes.
// Optional perf counters are enabled by defining FORWARD_PERF_EN.

package operand_forward_pkg;
    typedef enum logic [1:0] {
        NO_FORWARD     = 2'd0,
        COMPUTE_RESULT = 2'd1,
        RD1_W          = 2'd2,
        RD1_POST_W     = 2'd3
    } forward_src_t;
endpackage

module operand_forward_stage
    import operand_forward_pkg::*;
#(
    parameter int unsigned XLEN  = 32,
    parameter int unsigned ADR_W = 5,
    parameter int unsigned CNT_W = 32
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [XLEN-1:0]    rs1Data_R,
    input  logic [XLEN-1:0]    rs2Data_R,
    input  logic               valid_R,
    input  forward_src_t       Rs1ForwardSrc_C,
    input  forward_src_t       Rs2ForwardSrc_C,
    input  logic               StallRC,
    input  logic               FlushCM,
    input  logic [XLEN-1:0]    computeResult_C,
    input  logic [ADR_W-1:0]   rd1Adr_C,
    input  logic [XLEN-1:0]    rd1Data_W,
    input  logic [ADR_W-1:0]   rd1Adr_W,
    input  logic               RegWrite_W,
    output logic [XLEN-1:0]    rs1Operand_C,
    output logic [XLEN-1:0]    rs2Operand_C,
    output logic               valid_C,
    output logic [XLEN-1:0]    computeResult_M,
    output logic [ADR_W-1:0]   rd1Adr_M,
    output logic               valid_M,
    output logic [CNT_W-1:0]   stallCycles,
    output logic [CNT_W-1:0]   forwardCount
);

    logic [XLEN-1:0] rs1_q;
    logic [XLEN-1:0] rs2_q;
    logic [XLEN-1:0] post_w_q;

    // R->C operand register; a stall holds the C-stage instruction in place
    always_ff @(posedge clk) begin
        if (reset) begin
            rs1_q   <= '0;
            rs2_q   <= '0;
            valid_C <= 1'b0;
        end else if (!StallRC) begin
            rs1_q   <= rs1Data_R;
            rs2_q   <= rs2Data_R;
            valid_C <= valid_R;
        end
    end

    // C->M result register; a flush inserts an all-zero bubble and wins over capture
    always_ff @(posedge clk) begin
        if (reset || FlushCM) begin
            computeResult_M <= '0;
            rd1Adr_M        <= '0;
            valid_M         <= 1'b0;
        end else begin
            computeResult_M <= computeResult_C;
            rd1Adr_M        <= rd1Adr_C;
            valid_M         <= valid_C;
        end
    end

    // Post-writeback register keeps the last value written to a non-x0 register
    always_ff @(posedge clk) begin
        if (reset) begin
            post_w_q <= '0;
        end else if (RegWrite_W && (rd1Adr_W != '0)) begin
            post_w_q <= rd1Data_W;
        end
    end

    // rs1 forwarding mux; unknown selects fall back to the registered operand
    always_comb begin
        rs1Operand_C = rs1_q;
        case (Rs1ForwardSrc_C)
            COMPUTE_RESULT: rs1Operand_C = computeResult_M;
            RD1_W:          rs1Operand_C = rd1Data_W;
            RD1_POST_W:     rs1Operand_C = post_w_q;
            default:        rs1Operand_C = rs1_q;
        endcase
    end

    // rs2 forwarding mux; unknown selects fall back to the registered operand
    always_comb begin
        rs2Operand_C = rs2_q;
        case (Rs2ForwardSrc_C)
            COMPUTE_RESULT: rs2Operand_C = computeResult_M;
            RD1_W:          rs2Operand_C = rd1Data_W;
            RD1_POST_W:     rs2Operand_C = post_w_q;
            default:        rs2Operand_C = rs2_q;
        endcase
    end

`ifdef FORWARD_PERF_EN
    logic [CNT_W-1:0] stall_cnt_q;
    logic [CNT_W-1:0] fwd_cnt_q;
    logic             rs1_fwd;
    logic             rs2_fwd;
    logic [1:0]       fwd_inc;
    logic [CNT_W:0]   fwd_sum;

    // Forwarded-operand increment for this cycle (0, 1 or 2)
    always_comb begin
        rs1_fwd = (Rs1ForwardSrc_C == COMPUTE_RESULT) || (Rs1ForwardSrc_C == RD1_W) ||
                  (Rs1ForwardSrc_C == RD1_POST_W);
        rs2_fwd = (Rs2ForwardSrc_C == COMPUTE_RESULT) || (Rs2ForwardSrc_C == RD1_W) ||
                  (Rs2ForwardSrc_C == RD1_POST_W);
        fwd_inc = 2'b00;
        if (valid_C && !StallRC) begin
            fwd_inc = {1'b0, rs1_fwd} + {1'b0, rs2_fwd};
        end
        fwd_sum = {1'b0, fwd_cnt_q} + (CNT_W+1)'(fwd_inc);
    end

    // Saturating perf counters
    always_ff @(posedge clk) begin
        if (reset) begin
            stall_cnt_q <= '0;
            fwd_cnt_q   <= '0;
        end else begin
            if (StallRC && (stall_cnt_q != '1)) begin
                stall_cnt_q <= stall_cnt_q + CNT_W'(1);
            end
            if (fwd_sum[CNT_W]) begin
                fwd_cnt_q <= '1;
            end else begin
                fwd_cnt_q <= fwd_sum[CNT_W-1:0];
            end
        end
    end

    assign stallCycles  = stall_cnt_q;
    assign forwardCount = fwd_cnt_q;
`else
    assign stallCycles  = '0;
    assign forwardCount = '0;
`endif

endmodule
